// File: rtl/sw_debounce_sync.sv
// -----------------------------------------------------------------------------
// sw_debounce_sync
//
// Multi-channel switch conditioner. Each channel takes a raw, asynchronous,
// bouncing switch level and produces a clean, synchronous, debounced level
// plus single-cycle rise/fall pulses. The outputs are safe to use as D and
// clock-enable inputs of downstream storage elements.
//
// Parameters
//   WIDTH            number of independent switch channels
//   DEBOUNCE_CYCLES  consecutive stable synchronized cycles required before
//                    the debounced level may change (legal range >= 2)
//
// Ports
//   clk      in   1      sole clock, rising edge
//   rst      in   1      synchronous, active-high reset
//   sw_in    in   WIDTH  raw asynchronous switch levels
//   sw_out   out  WIDTH  debounced level per channel (registered)
//   rise     out  WIDTH  one-cycle pulse on an accepted 0->1 change (registered)
//   fall     out  WIDTH  one-cycle pulse on an accepted 1->0 change (registered)
//   changed  out  1      OR of all rise/fall bits of the same cycle (registered)
//
// Per channel: 2-flop synchronizer s1->s2, an IDLE/CHECK state bit, a run
// counter and the output registers. Only s2 feeds the qualification logic,
// so there is no combinational path from sw_in to any output.
// -----------------------------------------------------------------------------
module sw_debounce_sync #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    // Last count value before the level is accepted; the counter never
    // goes beyond it, so it cannot wrap.
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_e;

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    state_e           state_q [WIDTH];
    state_e           state_d [WIDTH];
    logic [CW-1:0]    cnt_q   [WIDTH];
    logic [CW-1:0]    cnt_d   [WIDTH];

    logic [WIDTH-1:0] sw_out_q;
    logic [WIDTH-1:0] sw_out_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             changed_q;
    logic             changed_d;

    // Per-channel qualification: next state, counter, level and pulses.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            sw_out_d[i] = sw_out_q[i];
            rise_d[i]   = 1'b0;
            fall_d[i]   = 1'b0;

            case (state_q[i])
                ST_IDLE: begin
                    if (s2_q[i] != sw_out_q[i]) begin
                        state_d[i] = ST_CHECK;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = CNT_ZERO;
                    end
                end
                ST_CHECK: begin
                    if (s2_q[i] == sw_out_q[i]) begin
                        // Bounce back to the current level: drop the run.
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] < CNT_TERM) begin
                        state_d[i] = ST_CHECK;
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end else begin
                        // Run long enough: accept the new level.
                        state_d[i]  = ST_IDLE;
                        cnt_d[i]    = CNT_ZERO;
                        sw_out_d[i] = s2_q[i];
                        rise_d[i]   = s2_q[i];
                        fall_d[i]   = ~s2_q[i];
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = CNT_ZERO;
                end
            endcase
        end

        changed_d = (|rise_d) | (|fall_d);
    end

    // State, synchronizer and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= {WIDTH{1'b0}};
            s2_q      <= {WIDTH{1'b0}};
            sw_out_q  <= {WIDTH{1'b0}};
            rise_q    <= {WIDTH{1'b0}};
            fall_q    <= {WIDTH{1'b0}};
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= CNT_ZERO;
            end
        end else begin
            s1_q      <= sw_in;
            s2_q      <= s1_q;
            sw_out_q  <= sw_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign sw_out  = sw_out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce_sync
//
// Bench for sw_debounce_sync (WIDTH=10, DEBOUNCE_CYCLES=4). A reference model
// tracks, per channel, how many consecutive synchronized cycles the input has
// disagreed with the debounced level; reaching DEBOUNCE_CYCLES flips the level
// and produces a pulse. Scenario tasks compare DUT outputs with the model and
// with hand-derived timing constants.
// -----------------------------------------------------------------------------
module tb_sw_debounce_sync;

    localparam int W = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] sw_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int n_checks = 0;
    int n_pass   = 0;

    sw_debounce_sync #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_in(sw_in),
        .sw_out(sw_out),
        .rise(rise),
        .fall(fall),
        .changed(changed)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_s1 = '0;
    logic [W-1:0] m_s2 = '0;
    logic [W-1:0] m_out = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_fall = '0;
    logic         m_changed = 1'b0;
    int           m_run [W];

    initial for (int i = 0; i < W; i++) m_run[i] = 0;

    function automatic logic any_accept();
        logic a = 1'b0;
        for (int i = 0; i < W; i++)
            if (m_s2[i] != m_out[i] && m_run[i] + 1 == D) a = 1'b1;
        return a;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s1 <= '0; m_s2 <= '0; m_out <= '0;
            m_rise <= '0; m_fall <= '0; m_changed <= 1'b0;
            for (int i = 0; i < W; i++) m_run[i] <= 0;
        end else begin
            m_s1 <= sw_in;
            m_s2 <= m_s1;
            m_changed <= any_accept();
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] != m_out[i] && m_run[i] + 1 == D) begin
                    m_out[i]  <= m_s2[i];
                    m_rise[i] <= m_s2[i];
                    m_fall[i] <= ~m_s2[i];
                    m_run[i]  <= 0;
                end else if (m_s2[i] != m_out[i]) begin
                    m_run[i]  <= m_run[i] + 1;
                    m_rise[i] <= 1'b0;
                    m_fall[i] <= 1'b0;
                end else begin
                    m_run[i]  <= 0;
                    m_rise[i] <= 1'b0;
                    m_fall[i] <= 1'b0;
                end
            end
        end
    end

    wire [3*W:0] dut_vec = {sw_out, rise, fall, changed};
    wire [3*W:0] mdl_vec = {m_out, m_rise, m_fall, m_changed};

    // Hold reset for two edges with the given input level, then release.
    task automatic apply_reset(input logic [W-1:0] v);
        rst   = 1'b1;
        sw_in = v;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst   = 1'b1;
        sw_in = 10'h3FF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (dut_vec !== '0) $display("FAIL reset_hold cyc%0d: got %h want 0", k, dut_vec);
            else n_pass++;
        end
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (sw_out !== ((k >= 5) ? 10'h3FF : 10'h000))
                $display("FAIL reset_rel_out edge%0d: got %h", k, sw_out);
            else n_pass++;
            n_checks++;
            if (rise !== ((k == 5) ? 10'h3FF : 10'h000) || changed !== (k == 5))
                $display("FAIL reset_rel_rise edge%0d: got rise=%h chg=%b", k, rise, changed);
            else n_pass++;
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL reset_model edge%0d: got %h want %h", k, dut_vec, mdl_vec);
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        apply_reset(10'h000);
        sw_in[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (sw_out[0] !== (k >= 5) || rise[0] !== (k == 5) || fall !== 10'h000)
                $display("FAIL press edge%0d: got out=%b rise=%b fall=%h", k, sw_out[0], rise[0], fall);
            else n_pass++;
        end
        sw_in[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (sw_out[0] !== (k < 5) || fall[0] !== (k == 5) || rise !== 10'h000)
                $display("FAIL release edge%0d: got out=%b fall=%b rise=%h", k, sw_out[0], fall[0], rise);
            else n_pass++;
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL release_model edge%0d: got %h want %h", k, dut_vec, mdl_vec);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int   rises = 0;
        apply_reset(10'h000);
        sw_in[3] = pat[0];
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (rise[3] === 1'b1) rises++;
            n_checks++;
            if (sw_out[3] !== (k >= 13) || rise[3] !== (k == 13))
                $display("FAIL bounce edge%0d: got out=%b rise=%b", k, sw_out[3], rise[3]);
            else n_pass++;
            sw_in[3] = (k + 1 < 8) ? pat[k + 1] : 1'b1;
        end
        n_checks++;
        if (rises != 1) $display("FAIL bounce_count: got %0d rises want 1", rises);
        else n_pass++;
    endtask

    task automatic test_glitch();
        apply_reset(10'h000);
        sw_in[5] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (sw_out[5] !== 1'b0 || rise[5] !== 1'b0 || fall[5] !== 1'b0 || changed !== 1'b0)
                $display("FAIL glitch3 edge%0d: got out=%b rise=%b fall=%b chg=%b",
                         k, sw_out[5], rise[5], fall[5], changed);
            else n_pass++;
            sw_in[5] = (k + 1 <= 2);
        end
        sw_in[5] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (sw_out[5] !== (k >= 5) || rise[5] !== (k == 5))
                $display("FAIL glitch4 edge%0d: got out=%b rise=%b", k, sw_out[5], rise[5]);
            else n_pass++;
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL glitch4_model edge%0d: got %h want %h", k, dut_vec, mdl_vec);
            else n_pass++;
            sw_in[5] = (k + 1 <= 3);
        end
    endtask

    task automatic test_simultaneous();
        int chg = 0;
        apply_reset(10'h000);
        sw_in[2] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        sw_in[1] = 1'b1;
        sw_in[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (changed === 1'b1) chg++;
            if (k == 5) begin
                n_checks++;
                if (rise !== 10'h002 || fall !== 10'h004 || changed !== 1'b1)
                    $display("FAIL simul_pulse: got rise=%h fall=%h chg=%b want 002 004 1", rise, fall, changed);
                else n_pass++;
            end
        end
        n_checks++;
        if (chg != 1) $display("FAIL simul_changed_count: got %0d want 1", chg);
        else n_pass++;
        n_checks++;
        if (sw_out !== 10'h002) $display("FAIL simul_level: got %h want 002", sw_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset(10'h000);
        sw_in[7] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (sw_out[7] !== 1'b0 || rise[7] !== 1'b0)
                $display("FAIL midrst_abort edge%0d: got out=%b rise=%b", k, sw_out[7], rise[7]);
            else n_pass++;
            rst = (k == 2);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (sw_out[7] !== (k >= 5) || rise[7] !== (k == 5))
                $display("FAIL midrst_requal edge%0d: got out=%b rise=%b", k, sw_out[7], rise[7]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int bad = 0;
        apply_reset(10'h000);
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 5) == 0) sw_in[i] = ~sw_in[i];
            rst = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
            n_checks++;
            if (dut_vec !== mdl_vec || (rise & fall) !== 10'h000) begin
                bad++;
                if (bad <= 10) $display("FAIL random cyc%0d: got %h want %h", k, dut_vec, mdl_vec);
            end else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sw_debounce_sync.md
# sw_debounce_sync

Multi-channel input conditioner sitting directly upstream of the board's latch/flip-flop stages. It takes raw, asynchronous, bouncing slide-switch levels and produces clean, synchronous, debounced levels plus single-cycle rise/fall pulses. Those outputs can drive the D and clock-enable inputs of downstream storage elements without metastability or bounce-induced multiple captures.

## Interface
- `WIDTH`, default 10: number of independent switch channels.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles required before an output level change. Legal range is ≥ 2; hardware builds override it (e.g. 500000 at 50 MHz).
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `sw_in`, input, WIDTH: raw asynchronous switch levels.
- `sw_out`, output, WIDTH: debounced level per channel (registered).
- `rise`, output, WIDTH: one-cycle pulse when the corresponding `sw_out` bit goes 0→1 (registered).
- `fall`, output, WIDTH: one-cycle pulse when the corresponding `sw_out` bit goes 1→0 (registered).
- `changed`, output, 1: OR of all `rise` and `fall` bits in the same cycle (registered).

## Operation
- Each channel is fully independent. Per channel it holds:
  - a 2-flop synchronizer `s1`→`s2`;
  - a state bit (IDLE/CHECK);
  - a counter of width `$clog2(DEBOUNCE_CYCLES)+1`;
  - the `sw_out` bit and the `rise`/`fall` registers.
- Synchronizer: `s1 <= sw_in[i]`, `s2 <= s1` every cycle. Only `s2` is used downstream.
- **IDLE**, counter = 0:
  - if `s2 == sw_out`, stay in IDLE;
  - if `s2 != sw_out`, go to CHECK with counter = 1.
- **CHECK**:
  - if `s2 == sw_out` (bounce), return to IDLE with counter = 0 and no output change;
  - if `s2 != sw_out` and counter < `DEBOUNCE_CYCLES-1`, increment the counter;
  - if `s2 != sw_out` and counter == `DEBOUNCE_CYCLES-1`, set `sw_out <= s2`, pulse `rise` or `fall` according to the new value, return to IDLE with counter = 0.
- `rise`/`fall` are high for exactly one cycle per accepted transition; at all other times they are 0. `rise` and `fall` are never both high on the same channel.
- Any mismatch run shorter than `DEBOUNCE_CYCLES` synchronized cycles is discarded entirely.
- Counter never wraps: the maximum value reached is `DEBOUNCE_CYCLES-1`.

## Timing
- Reset (`rst`=1 at a rising edge) forces, for all channels: `s1`=`s2`=0, state IDLE, counter 0, `sw_out`=0, `rise`=`fall`=0, `changed`=0. Reset takes priority over every other event, including a counter reaching terminal count in the same cycle.
- Reset mid-count aborts the pending transition; no pulse is emitted.
- Latency: `sw_in` changes before edge 0 and then holds stable.
  - `s1` updates at edge 0 and `s2` at edge 1.
  - Counter reaches 1 at edge 2.
  - `sw_out` toggles at edge `DEBOUNCE_CYCLES+1`.
  - `rise`/`fall` and `changed` are high in the cycle following that edge.
- After reset release with `sw_in[i]`=1, channel i produces `sw_out`=1 and a `rise` pulse `DEBOUNCE_CYCLES+1` edges after the first non-reset edge. This is intended, so downstream logic sees initial "on" switches as events.
- Multiple channels completing on the same edge each pulse their own bit; `changed` is a single 1-cycle pulse.
- No combinational path from `sw_in` to any output.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `sw_in`=10'h3FF -> all outputs 0 during reset. With `DEBOUNCE_CYCLES`=4, after release `sw_out`=10'h3FF at edge 5, `rise`=10'h3FF and `changed`=1 for exactly one cycle.
- Clean press, `DEBOUNCE_CYCLES`=4: `sw_in[0]` 0→1 before edge 0 and held -> `sw_out[0]` goes high at edge 5, `rise[0]` high one cycle, `fall`=0. Then 1→0 -> `sw_out[0]` low 5 edges later with a single `fall[0]` pulse.
- Bounce rejection: `sw_in[3]` toggles 1,0,1,0 with each level held 2 cycles, then settles to 1 -> exactly one `rise[3]`, issued 5 edges after settling. `sw_out[3]` never glitches.
- Short glitch: `sw_in[5]` high for 3 cycles then low, with `DEBOUNCE_CYCLES`=4 -> `sw_out[5]` stays 0 and no pulses. A 4-cycle high (after sync) is accepted.
- Simultaneous channels: `sw_in[1]` rises and `sw_in[2]` falls (from debounced 1) on the same cycle -> `rise[1]` and `fall[2]` in the same cycle, `changed` high exactly one cycle.
- Reset mid-count: `sw_in[7]` rises, assert `rst` 2 edges before terminal count -> no `rise[7]`, `sw_out[7]`=0. After release, the transition is re-qualified from scratch (5 edges).
